// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: core control, program RAM read port and decoder feed.
interface instr_fetch_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  en;
  logic                  stall;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-2:0] mem_addr;
  logic [WIDTH-1:0]      mem_rdata;
  logic [WIDTH-1:0]      long_instr;
  logic                  instr_choose;
  logic                  instr_valid;
  logic [ADDR_WIDTH-1:0] pc;

  // Fetch unit side
  modport master (
    input  en, stall, jump_en, jump_addr, mem_rdata,
    output mem_rd_en, mem_addr, long_instr, instr_choose, instr_valid, pc
  );

  // Core / RAM / decoder side
  modport slave (
    output en, stall, jump_en, jump_addr, mem_rdata,
    input  mem_rd_en, mem_addr, long_instr, instr_choose, instr_valid, pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads words from synchronous program RAM, splits each
// into one long or two short instructions (upper half first) and strobes them
// to the decoder, with stall and jump redirect handling.
module instr_fetch #(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]      long_q, long_d;
  logic                  valid_q, valid_d;
  logic                  choose_q, choose_d;

  assign bus.mem_rd_en    = (state_q == FETCH);
  assign bus.mem_addr     = pc_q[ADDR_WIDTH-1:1];
  assign bus.long_instr   = long_q;
  assign bus.instr_choose = choose_q;
  assign bus.instr_valid  = valid_q;
  assign bus.pc           = pc_q;

  // Register the FSM state, PC, buffered word and decoder strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      long_q   <= '0;
      valid_q  <= 1'b0;
      choose_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      long_q   <= long_d;
      valid_q  <= valid_d;
      choose_q <= choose_d;
    end
  end

  // Next-state logic: jump beats stall/disable, which beats normal sequencing.
  // In ISSUE an instruction only counts as consumed at an edge where it was
  // being presented (valid_q) and the decoder was not stalled; after a stall
  // it is first re-presented for one cycle before the PC moves on.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    long_d  = long_q;
    valid_d = 1'b0;
    if (bus.jump_en) begin
      pc_d    = bus.jump_addr;
      state_d = FETCH;
      long_d  = '0;
    end else if (bus.stall || !bus.en) begin
      state_d = state_q;
    end else begin
      unique case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: state_d = WAIT;
        WAIT: begin
          long_d  = bus.mem_rdata;
          state_d = ISSUE;
          valid_d = 1'b1;
        end
        ISSUE: begin
          if (!valid_q) begin
            valid_d = 1'b1;
          end else if (pc_q[0]) begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end else if (long_q[WIDTH-1]) begin
            pc_d    = pc_q + ADDR_WIDTH'(2);
            state_d = FETCH;
          end else begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    choose_d = pc_d[0];
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a synchronous program RAM model.
module tb_instr_fetch;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 16;

  logic clk;
  logic reset;
  int   nAsserts;
  int   nFail;

  logic [WIDTH-1:0] mem [0:(1<<(ADDR_WIDTH-1))-1];
  logic [WIDTH-1:0] memRdata;

  instr_fetch_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  instr_fetch #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: data appears one cycle after the read strobe and is held.
  always @(posedge clk) begin
    if (bus.mem_rd_en) memRdata <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = memRdata;

  task automatic applyStimulus(input logic en, input logic stall,
                               input logic jumpEn, input logic [ADDR_WIDTH-1:0] jumpAddr);
    bus.en        = en;
    bus.stall     = stall;
    bus.jump_en   = jumpEn;
    bus.jump_addr = jumpAddr;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected)
      else begin
        nFail++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    nAsserts = 0;
    nFail    = 0;
    memRdata = '0;
    for (int i = 0; i < (1 << (ADDR_WIDTH-1)); i++) mem[i] = '0;
    mem[0]      = 32'h8C00_1234;
    mem[1]      = 32'h4ABC_1283;
    mem[2]      = 32'h8000_0055;
    mem[8]      = 32'h1111_2222;
    mem[9]      = 32'h9999_0000;
    mem[16'h7FFF] = 32'hC0DE_0001;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    nextCycle();
    nextCycle();
    checkOutput("rst_valid",  bus.instr_valid,  1'b0);
    checkOutput("rst_pc",     bus.pc,           16'h0000);
    checkOutput("rst_long",   bus.long_instr,   32'h0);
    checkOutput("rst_choose", bus.instr_choose, 1'b0);
    checkOutput("rst_rden",   bus.mem_rd_en,    1'b0);

    // Long instruction at address 0
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    nextCycle();
    checkOutput("t1_c1_rden",  bus.mem_rd_en, 1'b1);
    checkOutput("t1_c1_addr",  bus.mem_addr,  15'h0000);
    checkOutput("t1_c1_valid", bus.instr_valid, 1'b0);
    nextCycle();
    checkOutput("t1_c2_rden",  bus.mem_rd_en, 1'b0);
    checkOutput("t1_c2_valid", bus.instr_valid, 1'b0);
    nextCycle();
    checkOutput("t1_c3_valid",  bus.instr_valid,  1'b1);
    checkOutput("t1_c3_long",   bus.long_instr,   32'h8C00_1234);
    checkOutput("t1_c3_choose", bus.instr_choose, 1'b0);
    checkOutput("t1_c3_pc",     bus.pc,           16'h0000);
    nextCycle();
    checkOutput("t1_next_pc",    bus.pc,          16'h0002);
    checkOutput("t1_next_addr",  bus.mem_addr,    15'h0001);
    checkOutput("t1_next_rden",  bus.mem_rd_en,   1'b1);
    checkOutput("t1_next_valid", bus.instr_valid, 1'b0);

    // Word holding two shorts at pc=2, stalled while the upper half is issued
    nextCycle();
    checkOutput("t2_wait_rden", bus.mem_rd_en, 1'b0);
    nextCycle();
    checkOutput("t2_up_valid",  bus.instr_valid,  1'b1);
    checkOutput("t2_up_choose", bus.instr_choose, 1'b0);
    checkOutput("t2_up_pc",     bus.pc,           16'h0002);
    checkOutput("t2_up_long",   bus.long_instr,   32'h4ABC_1283);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput($sformatf("t3_stall%0d_valid", i), bus.instr_valid, 1'b0);
      checkOutput($sformatf("t3_stall%0d_pc", i),    bus.pc,          16'h0002);
      checkOutput($sformatf("t3_stall%0d_rden", i),  bus.mem_rd_en,   1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    nextCycle();
    checkOutput("t3_rel_valid",  bus.instr_valid,  1'b1);
    checkOutput("t3_rel_choose", bus.instr_choose, 1'b0);
    checkOutput("t3_rel_pc",     bus.pc,           16'h0002);
    nextCycle();
    checkOutput("t2_lo_valid",  bus.instr_valid,  1'b1);
    checkOutput("t2_lo_choose", bus.instr_choose, 1'b1);
    checkOutput("t2_lo_pc",     bus.pc,           16'h0003);
    checkOutput("t2_lo_rden",   bus.mem_rd_en,    1'b0);
    nextCycle();
    checkOutput("t2_next_valid", bus.instr_valid, 1'b0);
    checkOutput("t2_next_rden",  bus.mem_rd_en,   1'b1);
    checkOutput("t2_next_addr",  bus.mem_addr,    15'h0002);

    // Jump issued while the read of mem[2] is in flight
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0011);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("t4_rden",  bus.mem_rd_en,   1'b1);
    checkOutput("t4_addr",  bus.mem_addr,    15'h0008);
    checkOutput("t4_pc",    bus.pc,          16'h0011);
    checkOutput("t4_valid", bus.instr_valid, 1'b0);
    nextCycle();
    checkOutput("t4_wait_valid", bus.instr_valid, 1'b0);
    nextCycle();
    checkOutput("t4_valid1",  bus.instr_valid,  1'b1);
    checkOutput("t4_choose1", bus.instr_choose, 1'b1);
    checkOutput("t4_pc1",     bus.pc,           16'h0011);
    checkOutput("t4_long1",   bus.long_instr,   32'h1111_2222);
    nextCycle();
    checkOutput("t4_after_pc",   bus.pc,       16'h0012);
    checkOutput("t4_after_addr", bus.mem_addr, 15'h0009);

    // Jump together with stall, then a long instruction at the top of memory
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFE);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("t5_jump_pc",   bus.pc,        16'hFFFE);
    checkOutput("t5_jump_addr", bus.mem_addr,  15'h7FFF);
    checkOutput("t5_jump_rden", bus.mem_rd_en, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("t5_top_valid", bus.instr_valid, 1'b1);
    checkOutput("t5_top_long",  bus.long_instr,  32'hC0DE_0001);
    checkOutput("t5_top_pc",    bus.pc,          16'hFFFE);
    nextCycle();
    checkOutput("t5_wrap_pc",   bus.pc,        16'h0000);
    checkOutput("t5_wrap_addr", bus.mem_addr,  15'h0000);
    checkOutput("t5_wrap_rden", bus.mem_rd_en, 1'b1);

    // Asynchronous reset while waiting on RAM data
    nextCycle();
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_async_valid",  bus.instr_valid,  1'b0);
    checkOutput("t6_async_long",   bus.long_instr,   32'h0);
    checkOutput("t6_async_pc",     bus.pc,           16'h0000);
    checkOutput("t6_async_choose", bus.instr_choose, 1'b0);
    checkOutput("t6_async_rden",   bus.mem_rd_en,    1'b0);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    checkOutput("t6_re_rden", bus.mem_rd_en, 1'b1);
    checkOutput("t6_re_addr", bus.mem_addr,  15'h0000);
    nextCycle();
    nextCycle();
    checkOutput("t6_re_valid", bus.instr_valid, 1'b1);
    checkOutput("t6_re_long",  bus.long_instr,  32'h8C00_1234);
    checkOutput("t6_re_pc",    bus.pc,          16'h0000);

    // Core disabled: FSM frozen, strobe dropped
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    nextCycle();
    checkOutput("en0_valid", bus.instr_valid, 1'b0);
    checkOutput("en0_pc",    bus.pc,          16'h0000);
    nextCycle();
    checkOutput("en0_hold_pc", bus.pc, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
